lsu: RTL and testbench
======================

// Module: lsu
// PURPOSE
//  Load/store unit of the hxd32 memory stage; sits directly upstream of wb.
//  Accepts one load/store request from EX, runs a single data-bus access under a ready/ack handshake,
//  lane-aligns read data to bit 0 and presents dram_rd_sel/dram_rd_data for wb to extend.
//  Detects misaligned accesses, which never reach the bus.
// PARAMETERS
//  XLEN  32  data/address width; only 32 supported (4 byte lanes)
// PORTS
//  clk_i           in   1     clock, all flops on rising edge
//  rst_n_i         in   1     reset, asynchronous, active-low
//  req_valid_i     in   1     EX request valid
//  req_ready_o     out  1     LSU can accept (state IDLE)
//  req_wr_i        in   1     1=store, 0=load
//  req_rd_sel_i    in   3     load type, DRAM_RD_* (ignored for stores)
//  req_wr_sel_i    in   2     store type, DRAM_WR_B/H/W (ignored for loads)
//  req_addr_i      in   XLEN  byte address
//  req_wr_data_i   in   XLEN  store data, value in low bits
//  bus_req_o       out  1     bus access in progress
//  bus_we_o        out  1     write strobe
//  bus_addr_o      out  XLEN  word address, [1:0]=2'b00
//  bus_be_o        out  4     byte enables
//  bus_wdata_o     out  XLEN  lane-replicated store data
//  bus_ack_i       in   1     access complete; read data valid same cycle
//  bus_rdata_i     in   XLEN  read word
//  rsp_valid_o     out  1     one-cycle completion pulse
//  misalign_o      out  1     qualifies rsp_valid_o: access was misaligned
//  dram_rd_sel_o   in-order out 3 load type for wb; DRAM_RD_NONE for stores/misaligned
//  dram_rd_data_o  out  XLEN  read data shifted so addressed byte/half is at bit 0
// BEHAVIOUR
//  Reset: state IDLE; bus_req_o, bus_we_o, rsp_valid_o, misalign_o = 0; bus_addr_o, bus_be_o,
//   bus_wdata_o, dram_rd_data_o = 0; dram_rd_sel_o = DRAM_RD_NONE. All outputs registered.
//  States: IDLE, BUS, RESP.
//  IDLE: req_ready_o=1. Accept on req_valid_i. Misaligned (H with addr[0]=1, W with addr[1:0]!=0)
//   -> RESP with misalign_o=1, no bus access. Aligned -> BUS; next cycle bus_req_o=1 with
//   bus_addr_o={addr[31:2],2'b00}, bus_we_o=req_wr_i.
//  BUS: bus signals held stable until bus_ack_i sampled high (n>=1 cycles). On ack: bus_req_o=0,
//   capture data, -> RESP. Latency accept->rsp_valid_o = n+1 cycles (misaligned: 1 cycle).
//  RESP: rsp_valid_o=1 for exactly one cycle, state returns to IDLE; req_ready_o=0 in RESP, so
//   back-to-back accept occurs the cycle after rsp_valid_o. dram_rd_sel_o/data hold until next RESP.
//  Byte enables: B -> 4'b0001<<addr[1:0]; H -> addr[1]?4'b1100:4'b0011; W -> 4'b1111.
//   Loads drive the same be pattern; bus_wdata_o=0 for loads.
//  Store data: B -> {4{wd[7:0]}}; H -> {2{wd[15:0]}}; W -> wd.
//  Load align: B/BU -> rdata>>(8*addr[1:0]); H/HU -> rdata>>(16*addr[1]); W -> rdata.
//   Upper bits after shift are passed through unmasked; wb performs extension.
//  req_valid_i outside IDLE is ignored (not queued). bus_ack_i outside BUS is ignored.
//  Async reset mid-access drops bus_req_o immediately; no response is produced for that request.
//  Unknown req_rd_sel_i on a load: bus access performed, dram_rd_sel_o forwards the value (wb zeroes).
// STRUCTURE
//  Shared package: DRAM_RD_B/H/W/BU/HU/NONE (existing 3-bit encodings), DRAM_WR_B/H/W (2-bit),
//   lsu_state_t enum {IDLE,BUS,RESP}.
//  One sub-module natural: lsu_lane (combinational be/wdata generation and read shift from
//   addr[1:0]+size); FSM and registers stay in lsu.
// TESTING
//  LB addr 0x103, rdata 0xAABBCCDD, ack after 2 cycles -> be=1000, addr 0x100, rsp at accept+3,
//   dram_rd_data[7:0]=0xAA, sel=DRAM_RD_B.
//  SH addr 0x202, wd 0x1234_5678, ack 1 cycle -> we=1, be=1100, wdata=0x5678_5678, sel=NONE.
//  LW addr 0x301 -> no bus_req_o, rsp_valid_o+misalign_o next cycle, sel=NONE.
//  Back-to-back LHU 0x10 / LW 0x14, ack same cycle as req -> second accepted cycle after 1st rsp,
//   data[15:0] from low half, then full word.
//  Assert rst_n_i=0 while bus_req_o=1 -> bus_req_o=0 immediately, no rsp_valid_o after release,
//   req_ready_o=1 first cycle after release.
//  Spurious bus_ack_i in IDLE and req_valid_i during BUS -> no state change, no extra rsp.

Source files
------------

// File: rtl/lsu_pkg.sv
// lsu_pkg: shared encodings, FSM state and access-size helpers for the load/store unit
package lsu_pkg;

  localparam int XLEN = 32;

  localparam logic [2:0] DRAM_RD_NONE = 3'd0;
  localparam logic [2:0] DRAM_RD_B    = 3'd1;
  localparam logic [2:0] DRAM_RD_H    = 3'd2;
  localparam logic [2:0] DRAM_RD_W    = 3'd3;
  localparam logic [2:0] DRAM_RD_BU   = 3'd4;
  localparam logic [2:0] DRAM_RD_HU   = 3'd5;

  localparam logic [1:0] DRAM_WR_B = 2'd0;
  localparam logic [1:0] DRAM_WR_H = 2'd1;
  localparam logic [1:0] DRAM_WR_W = 2'd2;

  typedef enum logic [1:0] {IDLE, BUS, RESP} lsu_state_t;
  typedef enum logic [1:0] {SZ_B, SZ_H, SZ_W} size_t;

  // Unknown load encodings fall back to a full-word access
  function automatic size_t rd_size(input logic [2:0] sel);
    return (sel == DRAM_RD_B || sel == DRAM_RD_BU) ? SZ_B :
           (sel == DRAM_RD_H || sel == DRAM_RD_HU) ? SZ_H : SZ_W;
  endfunction

  function automatic size_t wr_size(input logic [1:0] sel);
    return sel == DRAM_WR_B ? SZ_B : sel == DRAM_WR_H ? SZ_H : SZ_W;
  endfunction

  function automatic logic misaligned(input size_t sz, input logic [1:0] off);
    return (sz == SZ_H && off[0]) || (sz == SZ_W && off != 2'b00);
  endfunction

endpackage

// File: rtl/lsu_lane.sv
// lsu_lane: byte-enable/store-data lane replication and load-data alignment
module lsu_lane
  import lsu_pkg::*;
(
  input  size_t            size_i,
  input  logic [1:0]       off_i,
  input  logic [XLEN-1:0]  wd_i,
  input  logic [XLEN-1:0]  rdata_i,
  output logic [3:0]       be_o,
  output logic [XLEN-1:0]  wdata_o,
  output logic [XLEN-1:0]  rdata_o
);

  // Lane steering; upper bits of shifted read data are left for wb to extend
  always_comb begin
    be_o    = size_i == SZ_B ? 4'(4'b0001 << off_i) :
              size_i == SZ_H ? (off_i[1] ? 4'b1100 : 4'b0011) : 4'b1111;
    wdata_o = size_i == SZ_B ? {4{wd_i[7:0]}} :
              size_i == SZ_H ? {2{wd_i[15:0]}} : wd_i;
    rdata_o = size_i == SZ_B ? rdata_i >> {off_i, 3'b000} :
              size_i == SZ_H ? rdata_i >> {off_i[1], 4'b0000} : rdata_i;
  end

endmodule

// File: rtl/lsu.sv
// lsu: single-access load/store unit with ready/ack bus handshake and misalignment detection
module lsu
  import lsu_pkg::*;
(
  input  logic             clk_i,
  input  logic             rst_n_i,
  input  logic             req_valid_i,
  output logic             req_ready_o,
  input  logic             req_wr_i,
  input  logic [2:0]       req_rd_sel_i,
  input  logic [1:0]       req_wr_sel_i,
  input  logic [XLEN-1:0]  req_addr_i,
  input  logic [XLEN-1:0]  req_wr_data_i,
  output logic             bus_req_o,
  output logic             bus_we_o,
  output logic [XLEN-1:0]  bus_addr_o,
  output logic [3:0]       bus_be_o,
  output logic [XLEN-1:0]  bus_wdata_o,
  input  logic             bus_ack_i,
  input  logic [XLEN-1:0]  bus_rdata_i,
  output logic             rsp_valid_o,
  output logic             misalign_o,
  output logic [2:0]       dram_rd_sel_o,
  output logic [XLEN-1:0]  dram_rd_data_o
);

  lsu_state_t       state_q, state_d;
  size_t            op_size_q, op_size_d, req_size, lane_size;
  logic             op_wr_q, op_wr_d;
  logic [2:0]       op_sel_q, op_sel_d;
  logic [1:0]       op_off_q, op_off_d, lane_off;
  logic             accept, req_mis;
  logic             bus_req_q, bus_req_d, bus_we_q, bus_we_d;
  logic [XLEN-1:0]  bus_addr_q, bus_addr_d, bus_wdata_q, bus_wdata_d;
  logic [3:0]       bus_be_q, bus_be_d;
  logic             rsp_valid_q, rsp_valid_d, misalign_q, misalign_d;
  logic [2:0]       dram_rd_sel_q, dram_rd_sel_d;
  logic [XLEN-1:0]  dram_rd_data_q, dram_rd_data_d;
  logic [3:0]       lane_be;
  logic [XLEN-1:0]  lane_wdata, lane_rdata;

  // Request decode; the lane uses the live request in IDLE and the latched one afterwards
  always_comb begin
    accept    = state_q == IDLE && req_valid_i;
    req_size  = req_wr_i ? wr_size(req_wr_sel_i) : rd_size(req_rd_sel_i);
    req_mis   = misaligned(req_size, req_addr_i[1:0]);
    lane_size = state_q == IDLE ? req_size : op_size_q;
    lane_off  = state_q == IDLE ? req_addr_i[1:0] : op_off_q;
  end

  lsu_lane u_lane (
    .size_i  (lane_size),
    .off_i   (lane_off),
    .wd_i    (req_wr_data_i),
    .rdata_i (bus_rdata_i),
    .be_o    (lane_be),
    .wdata_o (lane_wdata),
    .rdata_o (lane_rdata)
  );

  // State register
  always_ff @(posedge clk_i or negedge rst_n_i)
    if (!rst_n_i) state_q <= IDLE;
    else state_q <= state_d;

  // Next state: misaligned requests skip the bus and respond directly
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    state_d = accept ? (req_mis ? RESP : BUS) : IDLE;
      BUS:     state_d = bus_ack_i ? RESP : BUS;
      default: state_d = IDLE;
    endcase
  end

  // Output/next-register values; bus fields load on an aligned accept, results on entry to RESP
  always_comb begin
    op_wr_d        = op_wr_q;
    op_sel_d       = op_sel_q;
    op_off_d       = op_off_q;
    op_size_d      = op_size_q;
    bus_addr_d     = bus_addr_q;
    bus_be_d       = bus_be_q;
    bus_wdata_d    = bus_wdata_q;
    dram_rd_sel_d  = dram_rd_sel_q;
    dram_rd_data_d = dram_rd_data_q;
    bus_req_d      = state_d == BUS;
    bus_we_d       = state_d == BUS && (accept ? req_wr_i : op_wr_q);
    rsp_valid_d    = state_d == RESP;
    misalign_d     = accept && req_mis;
    if (accept && !req_mis) begin
      op_wr_d     = req_wr_i;
      op_sel_d    = req_rd_sel_i;
      op_off_d    = req_addr_i[1:0];
      op_size_d   = req_size;
      bus_addr_d  = {req_addr_i[XLEN-1:2], 2'b00};
      bus_be_d    = lane_be;
      bus_wdata_d = req_wr_i ? lane_wdata : '0;
    end
    if (accept && req_mis) begin
      dram_rd_sel_d  = DRAM_RD_NONE;
      dram_rd_data_d = '0;
    end
    if (state_q == BUS && bus_ack_i) begin
      dram_rd_sel_d  = op_wr_q ? DRAM_RD_NONE : op_sel_q;
      dram_rd_data_d = op_wr_q ? '0 : lane_rdata;
    end
  end

  // Registered outputs and latched request; reset drops the bus request immediately
  always_ff @(posedge clk_i or negedge rst_n_i)
    if (!rst_n_i) begin
      op_wr_q        <= 1'b0;
      op_sel_q       <= DRAM_RD_NONE;
      op_off_q       <= 2'b00;
      op_size_q      <= SZ_W;
      bus_req_q      <= 1'b0;
      bus_we_q       <= 1'b0;
      bus_addr_q     <= '0;
      bus_be_q       <= 4'b0000;
      bus_wdata_q    <= '0;
      rsp_valid_q    <= 1'b0;
      misalign_q     <= 1'b0;
      dram_rd_sel_q  <= DRAM_RD_NONE;
      dram_rd_data_q <= '0;
    end else begin
      op_wr_q        <= op_wr_d;
      op_sel_q       <= op_sel_d;
      op_off_q       <= op_off_d;
      op_size_q      <= op_size_d;
      bus_req_q      <= bus_req_d;
      bus_we_q       <= bus_we_d;
      bus_addr_q     <= bus_addr_d;
      bus_be_q       <= bus_be_d;
      bus_wdata_q    <= bus_wdata_d;
      rsp_valid_q    <= rsp_valid_d;
      misalign_q     <= misalign_d;
      dram_rd_sel_q  <= dram_rd_sel_d;
      dram_rd_data_q <= dram_rd_data_d;
    end

  // Port drive
  always_comb begin
    req_ready_o    = state_q == IDLE;
    bus_req_o      = bus_req_q;
    bus_we_o       = bus_we_q;
    bus_addr_o     = bus_addr_q;
    bus_be_o       = bus_be_q;
    bus_wdata_o    = bus_wdata_q;
    rsp_valid_o    = rsp_valid_q;
    misalign_o     = misalign_q;
    dram_rd_sel_o  = dram_rd_sel_q;
    dram_rd_data_o = dram_rd_data_q;
  end

endmodule

// File: tb/tb_lsu.sv
// tb_lsu: directed and randomized checks of lsu against a byte-level reference model
module tb_lsu;
  import lsu_pkg::*;

  logic        clk_i = 1'b0, rst_n_i = 1'b0;
  logic        req_valid_i = 1'b0, req_wr_i = 1'b0, bus_ack_i = 1'b0;
  logic [2:0]  req_rd_sel_i = 3'd0;
  logic [1:0]  req_wr_sel_i = 2'd0;
  logic [31:0] req_addr_i = '0, req_wr_data_i = '0, bus_rdata_i = '0;
  logic        req_ready_o, bus_req_o, bus_we_o, rsp_valid_o, misalign_o;
  logic [31:0] bus_addr_o, bus_wdata_o, dram_rd_data_o;
  logic [3:0]  bus_be_o;
  logic [2:0]  dram_rd_sel_o;
  int          compared = 0, mismatched = 0;

  lsu dut (
    .clk_i(clk_i), .rst_n_i(rst_n_i), .req_valid_i(req_valid_i), .req_ready_o(req_ready_o),
    .req_wr_i(req_wr_i), .req_rd_sel_i(req_rd_sel_i), .req_wr_sel_i(req_wr_sel_i),
    .req_addr_i(req_addr_i), .req_wr_data_i(req_wr_data_i), .bus_req_o(bus_req_o),
    .bus_we_o(bus_we_o), .bus_addr_o(bus_addr_o), .bus_be_o(bus_be_o), .bus_wdata_o(bus_wdata_o),
    .bus_ack_i(bus_ack_i), .bus_rdata_i(bus_rdata_i), .rsp_valid_o(rsp_valid_o),
    .misalign_o(misalign_o), .dram_rd_sel_o(dram_rd_sel_o), .dram_rd_data_o(dram_rd_data_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic int nbytes(input bit wr, input logic [2:0] rs, input logic [1:0] ws);
    if (wr) return ws == 2'd0 ? 1 : ws == 2'd1 ? 2 : 4;
    return (rs == 3'd1 || rs == 3'd4) ? 1 : (rs == 3'd2 || rs == 3'd5) ? 2 : 4;
  endfunction

  // One complete transaction: accept, n bus cycles with ack on the last, response, return to idle
  task automatic run_req(input bit wr, input logic [2:0] rs, input logic [1:0] ws,
                         input logic [31:0] a, input logic [31:0] wd, input logic [31:0] rd,
                         input int n, input bit noise);
    int nb = nbytes(wr, rs, ws);
    int off = int'(a[1:0]);
    bit mis = (off % nb) != 0;
    logic [3:0]  e_be = 4'(((1 << nb) - 1) << off);
    logic [31:0] e_wd = '0;
    logic [31:0] e_rd = nb == 4 ? rd : rd >> (8 * off);
    logic [2:0]  e_sel = (wr || mis) ? 3'd0 : rs;
    logic [31:0] e_data = (wr || mis) ? 32'd0 : e_rd;
    for (int i = 0; i < 4; i++) e_wd[8*i +: 8] = wr ? 8'(wd >> (8 * (i % nb))) : 8'd0;
    chk("ready_idle", {31'd0, req_ready_o}, 1);
    req_valid_i = 1'b1; req_wr_i = wr; req_rd_sel_i = rs; req_wr_sel_i = ws;
    req_addr_i = a; req_wr_data_i = wd;
    @(posedge clk_i); @(negedge clk_i);
    req_valid_i = 1'b0; req_addr_i = $urandom; req_wr_data_i = $urandom; req_wr_i = $urandom;
    if (!mis) begin
      for (int k = 1; k <= n; k++) begin
        chk("bus_req", {31'd0, bus_req_o}, 1);
        chk("bus_addr", bus_addr_o, {a[31:2], 2'b00});
        chk("bus_be", {28'd0, bus_be_o}, {28'd0, e_be});
        chk("bus_we", {31'd0, bus_we_o}, {31'd0, wr});
        chk("bus_wdata", bus_wdata_o, e_wd);
        chk("rsp_early", {31'd0, rsp_valid_o}, 0);
        if (noise) req_valid_i = 1'b1;
        bus_ack_i = k == n;
        bus_rdata_i = k == n ? rd : $urandom;
        @(posedge clk_i); @(negedge clk_i);
        bus_ack_i = 1'b0; req_valid_i = 1'b0;
      end
    end
    chk("rsp_valid", {31'd0, rsp_valid_o}, 1);
    chk("misalign", {31'd0, misalign_o}, {31'd0, mis});
    chk("bus_req_rsp", {31'd0, bus_req_o}, 0);
    chk("ready_rsp", {31'd0, req_ready_o}, 0);
    chk("rd_sel", {29'd0, dram_rd_sel_o}, {29'd0, e_sel});
    chk("rd_data", dram_rd_data_o, e_data);
    if (noise) bus_ack_i = 1'b1;
    @(posedge clk_i); @(negedge clk_i);
    bus_ack_i = 1'b0;
    chk("rsp_pulse", {31'd0, rsp_valid_o}, 0);
    chk("bus_req_idle", {31'd0, bus_req_o}, 0);
    chk("rd_data_hold", dram_rd_data_o, e_data);
  endtask

  initial begin
    logic [2:0] rs_tab [7] = '{3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd6, 3'd0};
    @(negedge clk_i); @(negedge clk_i);
    chk("rst_bus_req", {31'd0, bus_req_o}, 0);
    chk("rst_bus_we", {31'd0, bus_we_o}, 0);
    chk("rst_bus_addr", bus_addr_o, 0);
    chk("rst_bus_be", {28'd0, bus_be_o}, 0);
    chk("rst_bus_wdata", bus_wdata_o, 0);
    chk("rst_rsp", {31'd0, rsp_valid_o}, 0);
    chk("rst_misalign", {31'd0, misalign_o}, 0);
    chk("rst_rd_sel", {29'd0, dram_rd_sel_o}, {29'd0, DRAM_RD_NONE});
    chk("rst_rd_data", dram_rd_data_o, 0);
    rst_n_i = 1'b1;
    @(negedge clk_i);
    run_req(0, DRAM_RD_B, 2'd0, 32'h103, 32'h0, 32'hAABBCCDD, 2, 0);
    run_req(1, 3'd0, DRAM_WR_H, 32'h202, 32'h1234_5678, 32'h0, 1, 0);
    run_req(0, DRAM_RD_W, 2'd0, 32'h301, 32'h0, 32'h0, 1, 0);
    run_req(0, DRAM_RD_HU, 2'd0, 32'h10, 32'h0, 32'h8765_4321, 1, 0);
    run_req(0, DRAM_RD_W, 2'd0, 32'h14, 32'h0, 32'hCAFE_F00D, 1, 0);
    bus_ack_i = 1'b1;
    repeat (3) begin
      @(negedge clk_i);
      chk("spurious_ack_rsp", {31'd0, rsp_valid_o}, 0);
      chk("spurious_ack_ready", {31'd0, req_ready_o}, 1);
    end
    bus_ack_i = 1'b0;
    run_req(0, DRAM_RD_H, 2'd0, 32'h46, 32'h0, 32'h1122_3344, 3, 1);
    req_valid_i = 1'b1; req_wr_i = 1'b0; req_rd_sel_i = DRAM_RD_W; req_addr_i = 32'h80;
    @(posedge clk_i); @(negedge clk_i);
    req_valid_i = 1'b0;
    chk("pre_rst_bus_req", {31'd0, bus_req_o}, 1);
    #2 rst_n_i = 1'b0;
    #1 chk("async_drop", {31'd0, bus_req_o}, 0);
    @(negedge clk_i);
    rst_n_i = 1'b1;
    #1 chk("ready_after_rst", {31'd0, req_ready_o}, 1);
    repeat (3) begin
      @(negedge clk_i);
      chk("no_rsp_after_rst", {31'd0, rsp_valid_o}, 0);
    end
    for (int t = 0; t < 40; t++)
      run_req(1'($urandom), rs_tab[$urandom_range(0, 6)], 2'($urandom), $urandom, $urandom,
              $urandom, int'($urandom_range(1, 3)), 1'($urandom));
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
